// File: rtl/stage_memory_wb.sv
// Memory-access + writeback stage of the RV32I pipeline: issues data-memory loads/stores over a
// req/ready + rvalid handshake, aligns/extends load data and drives the register-file write port.
module stage_memory_wb #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [31:0]       ex_alu_result,
   input  logic [31:0]       ex_rs_data2,
   input  logic [4:0]        ex_rd,
   input  logic [2:0]        ex_funct3,
   input  logic [1:0]        ex_result_src,
   input  logic              ex_regfile_wr_enable,
   input  logic              ex_datamem_wr_enable,
   input  logic [31:0]       ex_instr_addr_plus,
   output logic              mem_stall,
   output logic              misalign_err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic [4:0]        wb_wr_addr,
   output logic [31:0]       wb_wr_data,
   output logic              wb_regfile_wr_enable
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t      state;
   logic [4:0]  rd_q;
   logic        wr_en_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        uns_q;

   logic        is_store;
   logic        is_mem;
   logic [1:0]  off;
   logic        misaligned;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] alu_or_link;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   assign mem_stall = (state != IDLE);

   // Lane/alignment decode; funct3[1:0] of 1x (incl. unsupported encodings) is a word access.
   always_comb begin
      is_store    = ex_datamem_wr_enable;
      is_mem      = is_store || (ex_result_src == 2'b01);
      off         = ex_alu_result[1:0];
      alu_or_link = (ex_result_src == 2'b10) ? ex_instr_addr_plus : ex_alu_result;
      be_c        = 4'b1111;
      wdata_c     = ex_rs_data2;
      misaligned  = 1'b0;
      case (ex_funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << off;
            wdata_c = {4{ex_rs_data2[7:0]}};
         end
         2'b01: begin
            be_c       = off[1] ? 4'b1100 : 4'b0011;
            wdata_c    = {2{ex_rs_data2[15:0]}};
            misaligned = off[0];
         end
         default: begin
            be_c       = 4'b1111;
            wdata_c    = ex_rs_data2;
            misaligned = (off != 2'b00);
         end
      endcase
   end

   always_comb begin
      byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         misalign_err         <= 1'b0;
         dmem_req             <= 1'b0;
         dmem_we              <= 1'b0;
         dmem_addr            <= '0;
         dmem_wdata           <= '0;
         dmem_be              <= '0;
         wb_wr_addr           <= '0;
         wb_wr_data           <= '0;
         wb_regfile_wr_enable <= 1'b0;
         rd_q                 <= '0;
         wr_en_q              <= 1'b0;
         off_q                <= '0;
         size_q               <= '0;
         uns_q                <= 1'b0;
      end else begin
         wb_regfile_wr_enable <= 1'b0;
         misalign_err         <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (!is_mem) begin
                     wb_wr_addr           <= ex_rd;
                     wb_wr_data           <= alu_or_link;
                     wb_regfile_wr_enable <= ex_regfile_wr_enable && (ex_rd != 5'd0);
                  end else if (misaligned) begin
                     misalign_err <= 1'b1;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= is_store;
                     dmem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                     dmem_wdata <= wdata_c;
                     dmem_be    <= be_c;
                     rd_q       <= ex_rd;
                     wr_en_q    <= ex_regfile_wr_enable && !is_store && (ex_rd != 5'd0);
                     off_q      <= off;
                     size_q     <= ex_funct3[1:0];
                     uns_q      <= ex_funct3[2];
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  state    <= dmem_we ? IDLE : RESP;
               end
            end
            RESP: begin
               if (dmem_rvalid) begin
                  wb_wr_addr           <= rd_q;
                  wb_wr_data           <= load_ext;
                  wb_regfile_wr_enable <= wr_en_q;
                  state                <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_memory_wb.sv
// Bench for stage_memory_wb: table of instructions with expected memory traffic and writeback,
// writebacks checked through a scoreboard queue, plus hand sequences for misalign and reset.
module tb_stage_memory_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs_data2;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic [1:0]  ex_result_src;
   logic        ex_regfile_wr_enable;
   logic        ex_datamem_wr_enable;
   logic [31:0] ex_instr_addr_plus;
   logic        mem_stall;
   logic        misalign_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        wb_regfile_wr_enable;

   stage_memory_wb #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
      .ex_rs_data2(ex_rs_data2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_result_src(ex_result_src), .ex_regfile_wr_enable(ex_regfile_wr_enable),
      .ex_datamem_wr_enable(ex_datamem_wr_enable), .ex_instr_addr_plus(ex_instr_addr_plus),
      .mem_stall(mem_stall), .misalign_err(misalign_err), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .wb_regfile_wr_enable(wb_regfile_wr_enable)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  src;
      logic        rwe;
      logic        dwe;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] rdata;
      int          rdly;
      int          vdly;
      logic        mis;
      logic        req;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        wb;
      logic [31:0] wbd;
   } vec_t;

   vec_t        vecs [0:17];
   logic [36:0] sb_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Every writeback strobe must match the oldest expected writeback.
   always @(negedge clk) begin
      if (wb_regfile_wr_enable !== 1'b0) begin
         if (sb_q.size() == 0) begin
            check("unexpected_wb", {27'h0, wb_wr_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = sb_q.pop_front();
            check("wb_addr", {27'h0, wb_wr_addr}, {27'h0, e[36:32]});
            check("wb_data", wb_wr_data, e[31:0]);
         end
      end
   end

   task automatic wait_idle(input string p);
      for (int k = 0; k < 20 && mem_stall !== 1'b0; k++) @(negedge clk);
      check({p, "_idle"}, {31'h0, mem_stall}, 32'h0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      wait_idle(p);
      ex_valid             = 1'b1;
      ex_funct3            = v.f3;
      ex_result_src        = v.src;
      ex_regfile_wr_enable = v.rwe;
      ex_datamem_wr_enable = v.dwe;
      ex_alu_result        = v.alu;
      ex_rs_data2          = v.rs2;
      ex_rd                = v.rd;
      ex_instr_addr_plus   = v.pc4;
      if (v.wb) sb_q.push_back({v.rd, v.wbd});
      @(posedge clk);
      #1 ex_valid = 1'b0;
      @(negedge clk);
      check({p, "_mis"}, {31'h0, misalign_err}, {31'h0, v.mis});
      check({p, "_stall"}, {31'h0, mem_stall}, {31'h0, v.req});
      if (!v.req) begin
         check({p, "_req"}, {31'h0, dmem_req}, 32'h0);
         check({p, "_wben"}, {31'h0, wb_regfile_wr_enable}, {31'h0, v.wb});
      end else begin
         for (int k = 0; k <= v.rdly; k++) begin
            check({p, "_req"}, {31'h0, dmem_req}, 32'h1);
            check({p, "_we"}, {31'h0, dmem_we}, {31'h0, v.dwe});
            check({p, "_addr"}, dmem_addr, v.addr);
            check({p, "_be"}, {28'h0, dmem_be}, {28'h0, v.be});
            check({p, "_wdata"}, dmem_wdata, v.wdata);
            check({p, "_stall_req"}, {31'h0, mem_stall}, 32'h1);
            dmem_ready = (k == v.rdly);
            @(negedge clk);
         end
         dmem_ready = 1'b0;
         check({p, "_req_done"}, {31'h0, dmem_req}, 32'h0);
         if (v.dwe) begin
            check({p, "_st_stall"}, {31'h0, mem_stall}, 32'h0);
            check({p, "_st_wben"}, {31'h0, wb_regfile_wr_enable}, 32'h0);
         end else begin
            dmem_rdata = v.rdata;
            for (int k = 0; k <= v.vdly; k++) begin
               check({p, "_resp_stall"}, {31'h0, mem_stall}, 32'h1);
               check({p, "_resp_wben"}, {31'h0, wb_regfile_wr_enable}, 32'h0);
               dmem_rvalid = (k == v.vdly);
               @(negedge clk);
            end
            dmem_rvalid = 1'b0;
            check({p, "_ld_wben"}, {31'h0, wb_regfile_wr_enable}, {31'h0, v.wb});
            check({p, "_ld_stall"}, {31'h0, mem_stall}, 32'h0);
         end
      end
   endtask

   task automatic check_all_zero(input string p);
      check({p, "_stall"}, {31'h0, mem_stall}, 32'h0);
      check({p, "_mis"}, {31'h0, misalign_err}, 32'h0);
      check({p, "_req"}, {31'h0, dmem_req}, 32'h0);
      check({p, "_we"}, {31'h0, dmem_we}, 32'h0);
      check({p, "_addr"}, dmem_addr, 32'h0);
      check({p, "_wdata"}, dmem_wdata, 32'h0);
      check({p, "_be"}, {28'h0, dmem_be}, 32'h0);
      check({p, "_wbaddr"}, {27'h0, wb_wr_addr}, 32'h0);
      check({p, "_wbdata"}, wb_wr_data, 32'h0);
      check({p, "_wben"}, {31'h0, wb_regfile_wr_enable}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            f3      src    rwe   dwe   alu           rs2           rd     pc4          rdata         rd rv mis   req   addr          be       wdata         wb    wbd
      vecs[0]  = '{3'b000, 2'b00, 1'b1, 1'b0, 32'h0000_0005, 32'h0,        5'd3,  32'h0,       32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_0005};
      vecs[1]  = '{3'b000, 2'b00, 1'b0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, 5'd0,  32'h0,       32'h0,        3, 0, 1'b0, 1'b1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b0, 32'h0};
      vecs[2]  = '{3'b000, 2'b01, 1'b1, 1'b0, 32'h0000_2002, 32'h0,        5'd5,  32'h0,       32'h0080_0000, 0, 2, 1'b0, 1'b1, 32'h0000_2000, 4'b0100, 32'h0,        1'b1, 32'hFFFF_FF80};
      vecs[3]  = '{3'b100, 2'b01, 1'b1, 1'b0, 32'h0000_2002, 32'h0,        5'd6,  32'h0,       32'h0080_0000, 0, 2, 1'b0, 1'b1, 32'h0000_2000, 4'b0100, 32'h0,        1'b1, 32'h0000_0080};
      vecs[4]  = '{3'b010, 2'b01, 1'b1, 1'b0, 32'h0000_3002, 32'h0,        5'd7,  32'h0,       32'h0,        0, 0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
      vecs[5]  = '{3'b000, 2'b10, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        5'd0,  32'h0000_0104, 32'h0,      0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
      vecs[6]  = '{3'b000, 2'b10, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        5'd1,  32'h0000_0104, 32'h0,      0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_0104};
      vecs[7]  = '{3'b001, 2'b00, 1'b0, 1'b1, 32'h0000_4002, 32'h1234_5678, 5'd0,  32'h0,       32'h0,        1, 0, 1'b0, 1'b1, 32'h0000_4000, 4'b1100, 32'h5678_5678, 1'b0, 32'h0};
      vecs[8]  = '{3'b001, 2'b01, 1'b1, 1'b0, 32'h0000_5002, 32'h0,        5'd7,  32'h0,       32'h8001_7FFF, 0, 0, 1'b0, 1'b1, 32'h0000_5000, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001};
      vecs[9]  = '{3'b101, 2'b01, 1'b1, 1'b0, 32'h0000_5000, 32'h0,        5'd8,  32'h0,       32'h8001_9ABC, 0, 1, 1'b0, 1'b1, 32'h0000_5000, 4'b0011, 32'h0,        1'b1, 32'h0000_9ABC};
      vecs[10] = '{3'b010, 2'b01, 1'b1, 1'b0, 32'h0000_6004, 32'h0,        5'd9,  32'h0,       32'hDEAD_BEEF, 2, 1, 1'b0, 1'b1, 32'h0000_6004, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
      vecs[11] = '{3'b010, 2'b00, 1'b0, 1'b1, 32'h0000_7000, 32'hCAFE_F00D, 5'd0,  32'h0,       32'h0,        0, 0, 1'b0, 1'b1, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
      vecs[12] = '{3'b001, 2'b00, 1'b0, 1'b1, 32'h0000_4001, 32'h0000_FFFF, 5'd0,  32'h0,       32'h0,        0, 0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
      vecs[13] = '{3'b000, 2'b01, 1'b1, 1'b0, 32'h0000_2001, 32'h0,        5'd10, 32'h0,       32'h0000_7F00, 1, 0, 1'b0, 1'b1, 32'h0000_2000, 4'b0010, 32'h0,        1'b1, 32'h0000_007F};
      vecs[14] = '{3'b011, 2'b01, 1'b1, 1'b0, 32'h0000_8000, 32'h0,        5'd11, 32'h0,       32'h1122_3344, 0, 0, 1'b0, 1'b1, 32'h0000_8000, 4'b1111, 32'h0,        1'b1, 32'h1122_3344};
      vecs[15] = '{3'b010, 2'b01, 1'b1, 1'b0, 32'h0000_9000, 32'h0,        5'd0,  32'h0,       32'h5555_5555, 0, 0, 1'b0, 1'b1, 32'h0000_9000, 4'b1111, 32'h0,        1'b0, 32'h0};
      vecs[16] = '{3'b000, 2'b00, 1'b0, 1'b0, 32'h0000_0077, 32'h0,        5'd4,  32'h0,       32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
      vecs[17] = '{3'b000, 2'b01, 1'b1, 1'b0, 32'h0000_2003, 32'h0,        5'd13, 32'h0,       32'h8000_0000, 0, 0, 1'b0, 1'b1, 32'h0000_2000, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};

      rst = 1'b1;
      ex_valid = 1'b0; ex_alu_result = '0; ex_rs_data2 = '0; ex_rd = '0; ex_funct3 = '0;
      ex_result_src = '0; ex_regfile_wr_enable = 1'b0; ex_datamem_wr_enable = 1'b0;
      ex_instr_addr_plus = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         run_vec(vecs[i], i);
         @(negedge clk);
         check($sformatf("v%0d_after_wben", i), {31'h0, wb_regfile_wr_enable}, 32'h0);
         check($sformatf("v%0d_after_mis", i), {31'h0, misalign_err}, 32'h0);
      end

      // Misaligned word immediately followed by an ALU op accepted on the very next edge.
      run_vec(vecs[4], 100);
      run_vec(vecs[0], 101);

      // rvalid outside RESP must not produce a writeback.
      @(negedge clk);
      dmem_rdata = 32'h1234_5678; dmem_rvalid = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      @(negedge clk);
      check("stray_rvalid_wben", {31'h0, wb_regfile_wr_enable}, 32'h0);

      // Reset while waiting in RESP aborts the load; a late rvalid is ignored.
      ex_valid = 1'b1; ex_funct3 = 3'b010; ex_result_src = 2'b01; ex_regfile_wr_enable = 1'b1;
      ex_datamem_wr_enable = 1'b0; ex_alu_result = 32'h0000_A000; ex_rd = 5'd12;
      @(posedge clk);
      #1 ex_valid = 1'b0;
      @(negedge clk);
      check("rst_seq_req", {31'h0, dmem_req}, 32'h1);
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      check("rst_seq_in_resp", {31'h0, mem_stall}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst_resp");
      dmem_rdata = 32'hFFFF_FFFF; dmem_rvalid = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check_all_zero("rst_late_rvalid");
      @(negedge clk);
      check("rst_no_wb", {31'h0, wb_regfile_wr_enable}, 32'h0);

      check("sb_empty", sb_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
